// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit RISC core: opcode map, instruction field
// positions, default widths and the fetch-stage state type.
package core_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OPC_HI     = 15;
  localparam int unsigned OPC_LO     = 12;
  localparam int unsigned JTGT_W     = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_ADDI = 4'hD;
  localparam logic [3:0] OP_SLT  = 4'hE;
  localparam logic [3:0] OP_SGT  = 4'hF;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack handshake with instruction memory
// and presents one instruction at a time to decode over valid/ready.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned           ADDR_W   = ADDR_W_DEF,
  parameter int unsigned           DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] link_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              req_q;
  logic [ADDR_W-1:0] inc_src;
  logic [ADDR_W-1:0] pc_inc;

  // One incrementer: pc+1 is only needed in FETCH, instr_pc+1 only in VALID.
  assign inc_src = (state == VALID) ? instr_pc : pc;
  assign pc_inc  = inc_src + ADDR_W'(1);

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign opcode      = instr[OPC_HI:OPC_LO];
  assign link_pc     = pc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
      req_q    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // An ack without our request outstanding is stale and dropped.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            pc       <= pc_inc;
            req_q    <= 1'b0;
            state    <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            if (redirect_en) pc <= redirect_pc;
            req_q <= 1'b1;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized memory contents and latencies checked
// against a transaction-level model of the expected fetch stream.
module tb_instr_fetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [11:0] instr_pc;
  logic [11:0] link_pc;
  logic        redirect_en = 1'b0;
  logic [11:0] redirect_pc = '0;

  instr_fetch_unit #(.ADDR_W(12), .DATA_W(16), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .link_pc(link_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wait_cnt = 0;
  bit spurious_en = 1'b0;

  // Reference model: next address to fetch and the instruction being presented.
  bit          holding = 1'b0;
  int          exp_pc = 0;
  int          exp_ipc = 0;
  logic [15:0] exp_instr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc, rdr, cap;
    int rpc_s;
    acc   = instr_valid && instr_ready;
    rdr   = redirect_en;
    rpc_s = int'(redirect_pc);
    cap   = imem_ack && imem_req;
    @(posedge clk);
    #1;
    if (cap) begin
      exp_instr = mem[exp_pc];
      exp_ipc   = exp_pc;
      exp_pc    = (exp_pc + 1) % 4096;
      holding   = 1'b1;
    end
    if (acc) begin
      holding = 1'b0;
      if (rdr) exp_pc = rpc_s;
    end
    // memory responder: ack after 'lat' cycles of request, plus stray acks while idle
    if (imem_ack) begin
      imem_ack = 1'b0;
    end else if (imem_req) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt   = 0;
      end
    end else begin
      wait_cnt = 0;
      if (spurious_en && instr_valid && $urandom_range(0, 3) == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'($urandom);
      end
    end
    chk("valid", 32'(instr_valid), 32'(holding));
    chk("req", 32'(imem_req), 32'(!holding));
    if (imem_req) chk("addr", 32'(imem_addr), exp_pc);
    if (holding) begin
      chk("instr", 32'(instr), 32'(exp_instr));
      chk("instr_pc", 32'(instr_pc), exp_ipc);
      chk("opcode", 32'(opcode), 32'(exp_instr >> 12));
      chk("link_pc", 32'(link_pc), (exp_ipc + 1) % 4096);
    end
  endtask

  task automatic wait_valid(input int budget);
    bit found;
    found = instr_valid;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = instr_valid;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_valid observed=timeout expected=instr_valid");
    end
  endtask

  task automatic run_until(input int target, input int budget);
    bit found;
    found = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (holding && exp_ipc == target) found = 1'b1;
    end
    instr_ready = 1'b0;
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL reach_%0h observed=not_reached expected=reached", target);
    end
  endtask

  initial begin
    int rc;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123;
    mem[5] = 16'hA040;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_instr_pc", 32'(instr_pc), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    rst = 1'b0;

    // first fetch with 1-cycle memory
    lat = 1;
    step();
    chk("t1_addr", 32'(imem_addr), 0);
    step();
    chk("t1_instr", 32'(instr), 32'h1123);
    chk("t1_opcode", 32'(opcode), 1);
    chk("t1_instr_pc", 32'(instr_pc), 0);

    // decode stalls for 5 cycles
    repeat (5) begin
      step();
      chk("t3_req_low", 32'(imem_req), 0);
      chk("t3_hold_pc", 32'(instr_pc), 0);
    end

    // release with a 3-cycle memory behind it
    lat = 3;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t3_next_addr", 32'(imem_addr), 1);
    rc = 0;
    for (int n = 0; n < 10 && !instr_valid; n++) begin
      if (imem_req) rc++;
      step();
    end
    chk("t2_req_cycles", rc, 3);
    chk("t2_instr_pc", 32'(instr_pc), 1);

    // jump at 0x005
    lat = 1;
    run_until(5, 40);
    chk("t4_opcode", 32'(opcode), 32'(OP_JMP));
    chk("t4_link", 32'(link_pc), 32'h006);
    redirect_en = 1'b1;
    redirect_pc = 12'h040;
    instr_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    chk("t4_target", 32'(imem_addr), 32'h040);
    wait_valid(10);

    // PC wrap at 0xFFF
    redirect_en = 1'b1;
    redirect_pc = 12'hFFF;
    instr_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    wait_valid(10);
    chk("t5_instr_pc", 32'(instr_pc), 32'hFFF);
    chk("t5_link", 32'(link_pc), 0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t5_wrap_addr", 32'(imem_addr), 0);
    wait_valid(10);

    // random traffic with stray acks and ignored redirects
    spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      instr_ready = $urandom_range(0, 1) == 1;
      redirect_en = $urandom_range(0, 3) == 0;
      redirect_pc = 12'($urandom);
      if (!imem_req) lat = $urandom_range(1, 4);
      step();
    end
    spurious_en = 1'b0;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    repeat (3) step();

    // reset mid-request, then a late ack
    lat = 3;
    if (holding) begin
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
    end
    step();
    chk("t6_req_pending", 32'(imem_req), 1);
    rst = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 0);
    chk("t6_valid", 32'(instr_valid), 0);
    chk("t6_instr", 32'(instr), 0);
    chk("t6_instr_pc", 32'(instr_pc), 0);
    chk("t6_addr", 32'(imem_addr), 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    holding    = 1'b0;
    exp_pc     = 0;
    wait_cnt   = 0;
    step();
    chk("t6_stale_ignored", 32'(instr_valid), 0);
    wait_valid(10);
    chk("t6_restart_instr", 32'(instr), 32'h1123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
